bus_arbiter_n: RTL
==================

# bus_arbiter_n

Parametrised N-master to 1-slave arbiter for the core's valid/ready memory bus. It replaces the fixed two-master mux with a registered grant and selectable fixed-priority or round-robin arbitration. The grant is held for exactly one transfer. It sits between the instruction/data/DMA masters and the shared memory or peripheral interconnect.

## Interface
- NUM_MASTERS, 2, number of masters; legal range 2..16
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; multiple of 8
- ROUND_ROBIN, 1, 1 = round-robin, 0 = fixed priority (master 0 highest)
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous, active-low reset
- m_valid  in  NUM_MASTERS  per-master request
- m_ready  out  NUM_MASTERS  per-master completion strobe
- m_addr  in  NUM_MASTERS*ADDR_WIDTH  packed addresses; master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_wdata  in  NUM_MASTERS*DATA_WIDTH  packed write data
- m_wstrb  in  NUM_MASTERS*DATA_WIDTH/8  packed byte strobes; all zero means read
- m_rdata  out  NUM_MASTERS*DATA_WIDTH  packed read data
- s_valid  out  1  slave request
- s_ready  in  1  slave completion
- s_addr  out  ADDR_WIDTH  slave address
- s_wdata  out  DATA_WIDTH  slave write data
- s_wstrb  out  DATA_WIDTH/8  slave byte strobes
- s_rdata  in  DATA_WIDTH  slave read data
- grant_id  out  clog2(NUM_MASTERS)  index of the current or last granted master (debug)

## Operation
- Registered state: fsm in {IDLE, BUSY}, grant index g, round-robin pointer rr_ptr.
- IDLE:
  - s_valid=0, all m_ready=0.
  - s_addr, s_wdata and s_wstrb are driven to 0.
  - If any m_valid is set, latch the winner into g and go to BUSY. Otherwise stay in IDLE.
- Winner selection:
  - ROUND_ROBIN=1: first set m_valid searching upward from rr_ptr, wrapping from NUM_MASTERS-1 to 0.
  - ROUND_ROBIN=0: lowest set index.
- BUSY:
  - s_valid = m_valid[g]. s_addr, s_wdata and s_wstrb come from master g.
  - m_ready[g] = s_ready & m_valid[g], combinational. All other m_ready are 0.
  - On s_valid & s_ready: return to IDLE. If ROUND_ROBIN=1, set rr_ptr to g+1, wrapping NUM_MASTERS-1 to 0.
  - If m_valid[g] deasserts with no handshake (protocol violation): return to IDLE, leave rr_ptr unchanged, generate no m_ready.
- Read data: m_rdata slice g = s_rdata, combinational, in BUSY only. All other slices, and all slices in IDLE, are 0.
- Masters that are not granted keep their requests pending. No request is dropped.
- grant_id = g. It holds its value in IDLE.

## Timing
- Reset values: fsm=IDLE, g=0, rr_ptr=0, so s_valid=0, m_ready=0, s_addr/s_wdata/s_wstrb=0, m_rdata=0, grant_id=0.
- Reset is synchronous and takes effect mid-transfer. The cycle after resetn is sampled low, fsm is IDLE and no m_ready is produced even if s_ready=1.
- Request latency: m_valid rises in cycle 0 with the arbiter idle, so s_valid=1 in cycle 1.
- Completion: the handshake cycle is the one where s_valid & s_ready. The master sees m_ready in that same cycle, with s_rdata valid.
- A mandatory dead cycle follows each handshake (IDLE, s_valid=0). Maximum throughput is one transfer per 2 cycles.
- A request pending at the handshake is granted in the dead cycle, and its s_valid appears in the cycle after.
- Simultaneous requests in IDLE: exactly one grant per the selection rule. Requests arriving while BUSY wait for the next IDLE cycle.
- Combinational paths: s_ready to m_ready, and s_rdata to m_rdata. No path from m_valid to m_ready bypasses g.

## Test plan
- Reset mid-transfer: master 1 granted, slave holding s_ready=0. Pull resetn low for 1 cycle -> next cycle s_valid=0, grant_id=0, m_ready=0, and a fresh request from master 1 is granted in the cycle after.
- Single read: NUM_MASTERS=4. Master 2 reads addr 0x1000 with wstrb 0; slave asserts s_ready on the 3rd cycle of s_valid with rdata 0xDEADBEEF -> m_ready[2] pulses once, m_rdata slice 2 = 0xDEADBEEF, other slices 0, then one cycle with s_valid=0.
- Round-robin fairness: NUM_MASTERS=4, all masters requesting continuously, zero-wait slave -> grant order 0,1,2,3,0,1. A transfer completes every 2 cycles.
- Fixed priority: ROUND_ROBIN=0, masters 1 and 3 requesting continuously -> master 1 granted on every transfer and master 3 never, until master 1 drops valid, after which master 3 is granted on the next transfer.
- Write routing: NUM_MASTERS=3. Master 0 writes 0x12345678 to 0x20 with wstrb 4'b0011 while master 1 is requesting -> s_addr/s_wdata/s_wstrb match master 0 exactly. Master 1's values never appear until its grant.
- Aborted request: master 1 granted, then drops m_valid before s_ready -> s_valid falls the same cycle, fsm returns to IDLE, rr_ptr unchanged, and master 1 is re-granted when it requests again.

Source files
------------

// File: rtl/bus_arbiter_n.sv
// N-master to 1-slave valid/ready bus arbiter with a registered grant held for one transfer.
// Selectable fixed-priority (master 0 highest) or round-robin winner selection.
module bus_arbiter_n #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter bit          ROUND_ROBIN = 1'b1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [NUM_MASTERS-1:0]              m_valid,
    output logic [NUM_MASTERS-1:0]              m_ready,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_wstrb,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_rdata,
    output logic                                s_valid,
    input  logic                                s_ready,
    output logic [ADDR_WIDTH-1:0]               s_addr,
    output logic [DATA_WIDTH-1:0]               s_wdata,
    output logic [DATA_WIDTH/8-1:0]             s_wstrb,
    input  logic [DATA_WIDTH-1:0]               s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0]      grant_id
);

    localparam int unsigned GW = $clog2(NUM_MASTERS);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam logic [GW:0]   NM   = (GW + 1)'(NUM_MASTERS);
    localparam logic [GW-1:0] LAST = GW'(NUM_MASTERS - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   g_q, g_d;
    logic [GW-1:0]   rr_ptr_q, rr_ptr_d;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_MASTERS];
    logic [SW-1:0]         wstrb_arr [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] sel;

    logic          busy;
    logic [GW-1:0] win;
    logic [GW-1:0] base;
    logic [GW-1:0] idx;
    logic [GW:0]   sum;
    logic          found;

    assign busy     = (state_q == StBusy);
    assign grant_id = g_q;

    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_master
        assign addr_arr[i]  = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_arr[i] = m_wstrb[i*SW +: SW];
        assign sel[i]       = busy && (g_q == GW'(i));
        assign m_ready[i]   = sel[i] & s_ready & m_valid[i];
        assign m_rdata[i*DATA_WIDTH +: DATA_WIDTH] = sel[i] ? s_rdata : '0;
    end

    // Search upward from base with wrap; base is 0 in fixed-priority mode.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        base  = ROUND_ROBIN ? rr_ptr_q : '0;
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            sum = {1'b0, base} + (GW + 1)'(i);
            if (sum >= NM) begin
                sum = sum - NM;
            end
            idx = sum[GW-1:0];
            if (!found && m_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        rr_ptr_d = rr_ptr_q;
        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    g_d     = win;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                s_valid = m_valid[g_q];
                s_addr  = addr_arr[g_q];
                s_wdata = wdata_arr[g_q];
                s_wstrb = wstrb_arr[g_q];
                // A withdrawn request abandons the grant without advancing fairness.
                if (!m_valid[g_q]) begin
                    state_d = StIdle;
                end else if (s_ready) begin
                    state_d = StIdle;
                    if (ROUND_ROBIN) begin
                        rr_ptr_d = (g_q == LAST) ? '0 : g_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            g_q      <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
